// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one two-port SRAM between N_REQ requesters.
//
// Independent round-robin arbiters on the read and write ports, with
// same-address read/write collisions resolved in favour of the write.
// Read data comes back one cycle after the grant, tagged with a one-hot
// valid that mirrors the grant.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   rd_req/rd_addr     per-requester read request and packed addresses
//   rd_gnt             one-hot read grant (same cycle)
//   rd_rsp_valid/data  one-hot response valid, shared read data
//   wr_req/addr/data   per-requester write request, packed address/data
//   wr_gnt             one-hot write grant (same cycle)
//   sram_*             SRAM wrapper interface, rEn/wEn active-low
//
// Build option: define SRAM_ARB_STATS_EN to add saturating 16-bit
// rd_stall_cnt, wr_stall_cnt and collision_cnt outputs.
module sram_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int L_data = 16,
    parameter int L_addr = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          rd_req,
    input  logic [N_REQ*L_addr-1:0]   rd_addr,
    output logic [N_REQ-1:0]          rd_gnt,
    output logic [N_REQ-1:0]          rd_rsp_valid,
    output logic [L_data-1:0]         rd_rsp_data,
    input  logic [N_REQ-1:0]          wr_req,
    input  logic [N_REQ*L_addr-1:0]   wr_addr,
    input  logic [N_REQ*L_data-1:0]   wr_data,
    output logic [N_REQ-1:0]          wr_gnt,
    output logic                      sram_rEn,
    output logic [L_addr-1:0]         sram_rAddr,
    output logic                      sram_wEn,
    output logic [L_addr-1:0]         sram_wAddr,
    output logic [L_data-1:0]         sram_wData,
`ifdef SRAM_ARB_STATS_EN
    output logic [15:0]               rd_stall_cnt,
    output logic [15:0]               wr_stall_cnt,
    output logic [15:0]               collision_cnt,
`endif
    input  logic [L_data-1:0]         sram_rData
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_pick, wr_pick;
    logic [PW-1:0]    rd_k, wr_k;
    logic             rd_en, wr_en, collision;
    logic [N_REQ-1:0] rsp_sel_q;

    // Returns {found, index} of the first set req bit at or after ptr.
    // Scanning offsets downwards lets the lowest offset win.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] r;
        int idx;
        r = '0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            idx = (int'(ptr) + o) % N_REQ;
            if (req[idx]) r = {1'b1, idx[PW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        rd_pick     = rr_pick(rd_req, rd_ptr_q);
        wr_pick     = rr_pick(wr_req, wr_ptr_q);
        rd_k        = rd_pick[PW-1:0];
        wr_k        = wr_pick[PW-1:0];
        sram_wAddr  = wr_addr[int'(wr_k)*L_addr +: L_addr];
        sram_wData  = wr_data[int'(wr_k)*L_data +: L_data];
        sram_rAddr  = rd_addr[int'(rd_k)*L_addr +: L_addr];
        wr_en       = rst_n && wr_pick[PW];
        // A read hitting the address being written this cycle waits one
        // cycle so it observes the new data; writes never wait.
        collision   = wr_en && rd_pick[PW] && (sram_rAddr == sram_wAddr);
        rd_en       = rst_n && rd_pick[PW] && !collision;
        sram_wEn    = !wr_en;
        sram_rEn    = !rd_en;
        wr_gnt      = wr_en ? (ONE << wr_k) : '0;
        rd_gnt      = rd_en ? (ONE << rd_k) : '0;
        wr_ptr_d    = wr_en ? ((wr_k == PW'(N_REQ - 1)) ? '0 : wr_k + 1'b1) : wr_ptr_q;
        rd_ptr_d    = rd_en ? ((rd_k == PW'(N_REQ - 1)) ? '0 : rd_k + 1'b1) : rd_ptr_q;
        // Gating with rst_n drops a response whose grant preceded reset.
        rd_rsp_valid = rst_n ? rsp_sel_q : '0;
        rd_rsp_data  = sram_rData;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rsp_sel_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rsp_sel_q <= rd_gnt;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic rd_stall, wr_stall;

    always_comb begin
        rd_stall = (|rd_req) && !rd_en;
        wr_stall = |(wr_req & ~wr_gnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_stall_cnt  <= '0;
            wr_stall_cnt  <= '0;
            collision_cnt <= '0;
        end else begin
            rd_stall_cnt  <= rd_stall_cnt + {15'd0, rd_stall && (rd_stall_cnt != 16'hFFFF)};
            wr_stall_cnt  <= wr_stall_cnt + {15'd0, wr_stall && (wr_stall_cnt != 16'hFFFF)};
            collision_cnt <= collision_cnt + {15'd0, collision && (collision_cnt != 16'hFFFF)};
        end
    end
`endif

endmodule
